// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared encodings, FSM states and address-split widths for dcache_wt
package dcache_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  function automatic int word_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 0;
  endfunction

  function automatic int off_w(input int line_words);
    return 2 + word_w(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int data_width, input int line_words, input int sets);
    return data_width - off_w(line_words) - idx_w(sets);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load byte/half extract with sign/zero extension, store strobe and lane shift
module lsu_align
  import dcache_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] load_word_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_lanes_o,
  output logic [3:0]  store_strb_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = load_word_i[{byte_off_i, 3'b000} +: 8];
    sel_half = byte_off_i[1] ? load_word_i[31:16] : load_word_i[15:0];
    case (funct3_i)
      F3_B:    load_data_o = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data_o = {24'h0, sel_byte};
      F3_H:    load_data_o = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data_o = {16'h0, sel_half};
      default: load_data_o = load_word_i;
    endcase
  end

  // Narrow store data is replicated so every enabled lane already carries the right byte.
  always_comb begin
    case (funct3_i)
      F3_B: begin
        store_strb_o  = 4'b0001 << byte_off_i;
        store_lanes_o = {4{store_data_i[7:0]}};
      end
      F3_H: begin
        store_strb_o  = byte_off_i[1] ? 4'b1100 : 4'b0011;
        store_lanes_o = {2{store_data_i[15:0]}};
      end
      default: begin
        store_strb_o  = 4'b1111;
        store_lanes_o = store_data_i;
      end
    endcase
  end

endmodule

// File: rtl/dcache_wt.sv
// rtl/dcache_wt.sv - direct-mapped write-through no-write-allocate data cache
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WORD_W = word_w(LINE_WORDS);
  localparam int BEAT_W = (WORD_W > 0) ? WORD_W : 1;
  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(DATA_WIDTH, LINE_WORDS, SETS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                store_done_q, store_done_d;
  logic [SETS-1:0]     valid_q;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [BEAT_W-1:0]     word_sel;
  logic                  hit;
  logic [DATA_WIDTH-1:0] line_base;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_lanes;
  logic [3:0]            store_strb;

  assign idx       = addr[OFF_W +: IDX_W];
  assign tag       = addr[OFF_W+IDX_W +: TAG_W];
  assign word_sel  = (WORD_W > 0) ? addr[2 +: BEAT_W] : '0;
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign line_base = {addr[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  lsu_align u_align (
    .funct3_i      (funct3),
    .byte_off_i    (addr[1:0]),
    .load_word_i   (data_q[idx][word_sel]),
    .store_data_i  (wdata),
    .load_data_o   (load_data),
    .store_lanes_o (store_lanes),
    .store_strb_o  (store_strb)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    store_done_d = 1'b0;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = 4'b0000;
    rdata        = '0;
    case (state_q)
      IDLE: begin
        // store_done_q marks the retire cycle of a store that is still held by the core.
        if (req_valid && req_we && !store_done_q) begin
          stall   = 1'b1;
          state_d = WRITE;
        end else if (req_valid && !req_we) begin
          if (hit) begin
            rdata = load_data;
          end else begin
            stall   = 1'b1;
            state_d = REFILL;
            beat_d  = '0;
          end
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = line_base | (DATA_WIDTH'(beat_q) << 2);
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = IDLE;
        end
      end
      WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr[DATA_WIDTH-1:2], 2'b00};
        mem_wdata = store_lanes;
        mem_wstrb = store_strb;
        if (mem_ack) begin
          state_d      = IDLE;
          store_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      store_done_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      store_done_q <= store_done_d;
      if (state_q == REFILL && mem_ack && beat_q == LAST_BEAT) valid_q[idx] <= 1'b1;
    end
  end

  // Line storage carries no reset; valid_q alone decides whether contents are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && state_q == REFILL && mem_ack) begin
      data_q[idx][beat_q] <= mem_rdata;
      if (beat_q == LAST_BEAT) tag_q[idx] <= tag;
    end
    if (!rst && state_q == WRITE && mem_ack && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (store_strb[b]) data_q[idx][word_sel][8*b +: 8] <= store_lanes[8*b +: 8];
      end
    end
  end

endmodule
